// File: rtl/reg_transfer_bank.sv
// reg_transfer_bank
//   A bank of DEPTH registers, each WIDTH bits wide. It performs register-transfer
//   operations under a Start/Ready/Done handshake and has one combinational read port.
//
//   Ops:
//     000 NOP
//     001 LOAD  R[Dst] <= D
//     010 MOVE  R[Dst] <= R[Src]
//     011 SWAP  exchanges R[Src] and R[Dst] through TMP (multi-cycle)
//     100 ROTL  rotate left  (only when RTB_ROTATE_EN is defined, otherwise NOP)
//     101 ROTR  rotate right (only when RTB_ROTATE_EN is defined, otherwise NOP)
//     11x NOP
//
//   Build option: RTB_ROTATE_EN enables ROTL/ROTR.
//
//   Ports:
//     CLK     rising-edge clock
//     nRST    asynchronous active-low reset
//     Start   op request, accepted when Start && Ready
//     Op      op code
//     Src     source register index (AW bits)
//     Dst     destination register index (AW bits)
//     D       load data (WIDTH bits)
//     RdAddr  read-port index (AW bits)
//     Q       R[RdAddr], combinational; 0 for an index >= DEPTH
//     Ready   high while idle
//     Done    registered one-cycle pulse in the cycle after an op's last write
//
//   state | meaning
//   IDLE  | waiting for Start; single-cycle ops complete here
//   SW_T  | TMP holds old R[Src]; next edge writes R[Src] <= R[Dst]
//   SW_A  | next edge writes R[Dst] <= TMP
//   SW_B  | Done high; next edge returns to IDLE
module reg_transfer_bank #(
   parameter  int WIDTH = 3,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [AW-1:0]    Src,
   input  logic [AW-1:0]    Dst,
   input  logic [WIDTH-1:0] D,
   input  logic [AW-1:0]    RdAddr,
   output logic [WIDTH-1:0] Q,
   output logic             Ready,
   output logic             Done
);

   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_MOVE = 3'b010;
   localparam logic [2:0] OP_SWAP = 3'b011;
`ifdef RTB_ROTATE_EN
   localparam logic [2:0] OP_ROTL = 3'b100;
   localparam logic [2:0] OP_ROTR = 3'b101;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SW_T = 2'd1,
      SW_A = 2'd2,
      SW_B = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] r [DEPTH];
   logic [WIDTH-1:0] tmp;
   logic [AW-1:0]    src_q;
   logic [AW-1:0]    dst_q;

   // Out-of-range indices read as zero and have their writes dropped.
   logic             src_ok, dst_ok, dst_q_ok, src_q_ok, rd_ok;
   logic [WIDTH-1:0] rd_src, rd_dst, rd_dst_q;

   always_comb begin
      src_ok   = (int'(Src)    < DEPTH);
      dst_ok   = (int'(Dst)    < DEPTH);
      src_q_ok = (int'(src_q)  < DEPTH);
      dst_q_ok = (int'(dst_q)  < DEPTH);
      rd_ok    = (int'(RdAddr) < DEPTH);
      rd_src   = src_ok   ? r[Src]    : '0;
      rd_dst   = dst_ok   ? r[Dst]    : '0;
      rd_dst_q = dst_q_ok ? r[dst_q]  : '0;
      Q        = rd_ok    ? r[RdAddr] : '0;
   end

`ifdef RTB_ROTATE_EN
   // Built bit by bit so that WIDTH==1 degenerates to the identity.
   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] o;
      o = '0;
      for (int i = 0; i < WIDTH; i++) o[(i + 1) % WIDTH] = v[i];
      return o;
   endfunction

   function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] o;
      o = '0;
      for (int i = 0; i < WIDTH; i++) o[i] = v[(i + 1) % WIDTH];
      return o;
   endfunction
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) r[i] <= '0;
         tmp   <= '0;
         src_q <= '0;
         dst_q <= '0;
         state <= IDLE;
         Ready <= 1'b1;
         Done  <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start && Ready) begin
                  src_q <= Src;
                  dst_q <= Dst;
                  case (Op)
                     OP_LOAD: begin
                        if (dst_ok) r[Dst] <= D;
                        Done <= 1'b1;
                     end
                     OP_MOVE: begin
                        if (dst_ok) r[Dst] <= rd_src;
                        Done <= 1'b1;
                     end
                     OP_SWAP: begin
                        tmp   <= rd_src;
                        state <= SW_T;
                        Ready <= 1'b0;
                     end
`ifdef RTB_ROTATE_EN
                     OP_ROTL: begin
                        if (dst_ok) r[Dst] <= rotl(rd_dst);
                        Done <= 1'b1;
                     end
                     OP_ROTR: begin
                        if (dst_ok) r[Dst] <= rotr(rd_dst);
                        Done <= 1'b1;
                     end
`endif
                     default: ;
                  endcase
               end
            end
            SW_T: begin
               if (src_q_ok) r[src_q] <= rd_dst_q;
               state <= SW_A;
            end
            SW_A: begin
               if (dst_q_ok) r[dst_q] <= tmp;
               Done  <= 1'b1;
               state <= SW_B;
            end
            SW_B: begin
               Ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               Ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef RTB_ROTATE_EN
   // rd_dst only feeds the rotate ops.
   logic unused_ok;
   assign unused_ok = ^{rd_dst, 1'b0};
`endif

endmodule
